pixel_packer: RTL

//   Serial-to-parallel pixel gatherer. Accepts one pixel per clock over a valid/ready handshake.

---
 rtl/pixel_packer.sv | 83 ++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Gathers NUM_PIXELS serial pixels into one wide word (pixel 0 in LSBs) for memory write-back.
// Latency: value_valid rises on the second clock edge after the word-completing pixel is accepted.
// Backpressure: pixel_ready drops only when a word is complete and the output register is still unacked.
module pixel_packer #(
    parameter int NUM_PIXELS      = 16,
    parameter int PIXEL_WIDTH     = 16,
    parameter int VALUE_OUT_WIDTH = NUM_PIXELS * PIXEL_WIDTH,
    localparam int COUNT_WIDTH    = $clog2(NUM_PIXELS) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PIXEL_WIDTH-1:0]     pixel_in,
    input  logic                       pixel_valid,
    output logic                       pixel_ready,
    input  logic                       flush,
    output logic [VALUE_OUT_WIDTH-1:0] value_out,
    output logic [COUNT_WIDTH-1:0]     value_count,
    output logic                       value_valid,
    input  logic                       value_ack
);

    logic [COUNT_WIDTH-1:0]     fill_count;
    logic [COUNT_WIDTH-1:0]     fill_next;
    logic [VALUE_OUT_WIDTH-1:0] assembly;
    logic [VALUE_OUT_WIDTH-1:0] assembly_next;
    logic                       flush_pend;
    logic                       flush_pend_next;
    logic                       word_done;
    logic                       out_free;
    logic                       handoff;
    logic                       accept;

    assign word_done   = (fill_count == COUNT_WIDTH'(NUM_PIXELS)) |
                         (flush_pend & (fill_count != '0));
    assign out_free    = ~value_valid | value_ack;
    assign handoff     = word_done & out_free;
    assign pixel_ready = ~word_done | out_free;
    assign accept      = pixel_valid & pixel_ready;

    // A pixel accepted in the handoff cycle starts the fresh word in lane 0.
    always_comb begin
        fill_next       = fill_count;
        assembly_next   = assembly;
        flush_pend_next = flush_pend;
        if (handoff) begin
            fill_next       = '0;
            assembly_next   = '0;
            flush_pend_next = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (fill_next == COUNT_WIDTH'(i))
                    assembly_next[i*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_in;
            end
            fill_next = fill_next + COUNT_WIDTH'(1);
        end
        if (flush && (fill_next != '0))
            flush_pend_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_count  <= '0;
            assembly    <= '0;
            flush_pend  <= 1'b0;
            value_out   <= '0;
            value_count <= '0;
            value_valid <= 1'b0;
        end else begin
            fill_count <= fill_next;
            assembly   <= assembly_next;
            flush_pend <= flush_pend_next;
            if (handoff) begin
                value_out   <= assembly;
                value_count <= fill_count;
                value_valid <= 1'b1;
            end else if (value_valid && value_ack) begin
                value_valid <= 1'b0;
            end
        end
    end

endmodule
